// File: rtl/rob_circ_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rob_pkg
// Brief    : Shared instruction-type encodings and per-entry status layout
//            for the rob_circ reorder buffer.
// Revision : 1.0 - initial release
// ============================================================================
package rob_pkg;

    typedef logic [1:0] inst_type_t;

    localparam inst_type_t INST_REG    = 2'b00;
    localparam inst_type_t INST_BRANCH = 2'b01;
    localparam inst_type_t INST_STORE  = 2'b10;
    localparam inst_type_t INST_NODEST = 2'b11;

    // Narrow status part of an entry. The wide fields (rd_reg, pc, data) live
    // in parallel arrays so they need no reset and stay parameter-sized.
    typedef struct packed {
        logic       valid;
        logic       ready;
        logic       mispred;
        inst_type_t itype;
    } entry_flags_t;

endpackage : rob_pkg
`default_nettype wire

// File: rtl/rob_circ_if.sv
`default_nettype none
// ============================================================================
// Module   : rob_circ_if
// Brief    : Dispatch, operand-query, CDB and retire bundle of the reorder
//            buffer. master = pipeline side, slave = the ROB itself.
// Revision : 1.0 - initial release
// ============================================================================
interface rob_circ_if #(
    parameter int DEPTH    = 32,
    parameter int DATA_W   = 32,
    parameter int PC_W     = 32,
    parameter int NUM_REGS = 32
);
    localparam int TAG_W = $clog2(DEPTH);
    localparam int REG_W = $clog2(NUM_REGS);

    logic              disp_valid;
    logic              disp_ready;
    logic [REG_W-1:0]  disp_rd_reg;
    logic [PC_W-1:0]   disp_pc;
    logic [1:0]        disp_type;
    logic [TAG_W-1:0]  disp_tag;

    logic [REG_W-1:0]  rs_reg;
    logic [REG_W-1:0]  rt_reg;
    logic              rs_busy;
    logic              rt_busy;
    logic [TAG_W-1:0]  rs_tag;
    logic [TAG_W-1:0]  rt_tag;
    logic              rs_data_valid;
    logic              rt_data_valid;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;

    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              cdb_mispredict;

    logic              retire_valid;
    logic [TAG_W-1:0]  retire_tag;
    logic [REG_W-1:0]  retire_rd_reg;
    logic [1:0]        retire_type;
    logic [DATA_W-1:0] retire_data;
    logic [PC_W-1:0]   retire_pc;
    logic              retire_mispredict;
    logic              flush;

    logic [TAG_W:0]    occupancy;
    logic              full;
    logic              empty;

    modport master (
        output disp_valid, disp_rd_reg, disp_pc, disp_type,
        output rs_reg, rt_reg,
        output cdb_valid, cdb_tag, cdb_data, cdb_mispredict,
        input  disp_ready, disp_tag,
        input  rs_busy, rt_busy, rs_tag, rt_tag,
        input  rs_data_valid, rt_data_valid, rs_data, rt_data,
        input  retire_valid, retire_tag, retire_rd_reg, retire_type,
        input  retire_data, retire_pc, retire_mispredict, flush,
        input  occupancy, full, empty
    );

    modport slave (
        input  disp_valid, disp_rd_reg, disp_pc, disp_type,
        input  rs_reg, rt_reg,
        input  cdb_valid, cdb_tag, cdb_data, cdb_mispredict,
        output disp_ready, disp_tag,
        output rs_busy, rt_busy, rs_tag, rt_tag,
        output rs_data_valid, rt_data_valid, rs_data, rt_data,
        output retire_valid, retire_tag, retire_rd_reg, retire_type,
        output retire_data, retire_pc, retire_mispredict, flush,
        output occupancy, full, empty
    );

endinterface : rob_circ_if
`default_nettype wire

// File: rtl/rob_circ_rename_map.sv
`default_nettype none
// ============================================================================
// Module   : rob_rename_map
// Brief    : Architectural register -> {busy, producer tag} table with one
//            set port, one tag-qualified clear port, clear-all and two
//            combinational read ports.
// Revision : 1.0 - initial release
// ============================================================================
module rob_rename_map #(
    parameter int NUM_REGS = 32,
    parameter int TAG_W    = 5
) (
    input  wire logic                       clock,
    input  wire logic                       reset,
    input  wire logic                       set_en,
    input  wire logic [$clog2(NUM_REGS)-1:0] set_reg,
    input  wire logic [TAG_W-1:0]           set_tag,
    input  wire logic                       clr_en,
    input  wire logic [$clog2(NUM_REGS)-1:0] clr_reg,
    input  wire logic [TAG_W-1:0]           clr_tag,
    input  wire logic                       clr_all,
    input  wire logic [$clog2(NUM_REGS)-1:0] rd_a_reg,
    output logic                            rd_a_busy,
    output logic [TAG_W-1:0]                rd_a_tag,
    input  wire logic [$clog2(NUM_REGS)-1:0] rd_b_reg,
    output logic                            rd_b_busy,
    output logic [TAG_W-1:0]                rd_b_tag
);
    localparam int REG_W = $clog2(NUM_REGS);

    logic             busy [NUM_REGS];
    logic [TAG_W-1:0] tag  [NUM_REGS];

    // A new producer overrides a retiring one; the clear only hits when the
    // retiring tag is still the newest producer of that register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                busy[r] <= 1'b0;
                tag[r]  <= '0;
            end
        end else if (clr_all) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                busy[r] <= 1'b0;
                tag[r]  <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (set_en && set_reg == REG_W'(r)) begin
                    busy[r] <= 1'b1;
                    tag[r]  <= set_tag;
                end else if (clr_en && clr_reg == REG_W'(r) && tag[r] == clr_tag) begin
                    busy[r] <= 1'b0;
                end
            end
        end
    end

    // Read ports show state before any same-cycle update.
    always_comb begin
        rd_a_busy = busy[rd_a_reg];
        rd_a_tag  = tag[rd_a_reg];
        rd_b_busy = busy[rd_b_reg];
        rd_b_tag  = tag[rd_b_reg];
    end

endmodule : rob_rename_map
`default_nettype wire

// File: rtl/rob_circ.sv
`default_nettype none
// ============================================================================
// Module   : rob_circ
// Brief    : Circular reorder buffer with integrated rename map, two operand
//            query ports, CDB capture, in-order retire and head-of-queue
//            mispredict flush.
// Revision : 1.0 - initial release
// ============================================================================
module rob_circ
    import rob_pkg::*;
#(
    parameter int DEPTH    = 32,
    parameter int DATA_W   = 32,
    parameter int PC_W     = 32,
    parameter int NUM_REGS = 32
) (
    input  wire logic clock,
    input  wire logic reset,
    rob_circ_if.slave bus
);
    localparam int             TAG_W      = $clog2(DEPTH);
    localparam int             REG_W      = $clog2(NUM_REGS);
    localparam logic [TAG_W:0] FULL_COUNT = (TAG_W + 1)'(DEPTH);

    entry_flags_t      flags    [DEPTH];
    logic [REG_W-1:0]  ent_rd   [DEPTH];
    logic [PC_W-1:0]   ent_pc   [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];

    logic [TAG_W-1:0]  head;
    logic [TAG_W-1:0]  tail;
    logic [TAG_W:0]    count;

    entry_flags_t      head_flags;
    logic              retire_go;
    logic              flush_pending;
    logic              disp_go;
    logic              cdb_go;
    logic              rs_map_busy;
    logic              rt_map_busy;
    logic [TAG_W-1:0]  rs_map_tag;
    logic [TAG_W-1:0]  rt_map_tag;

    // Handshake and status decode; full/empty come from the counter so the
    // pointers are free to wrap.
    always_comb begin
        head_flags     = flags[head];
        retire_go      = head_flags.valid && head_flags.ready;
        flush_pending  = retire_go && head_flags.itype == INST_BRANCH && head_flags.mispred;
        bus.full       = count == FULL_COUNT;
        bus.empty      = count == '0;
        bus.occupancy  = count;
        bus.disp_ready = !bus.full && !flush_pending;
        bus.disp_tag   = tail;
        disp_go        = bus.disp_valid && bus.disp_ready;
        // Stale tags (invalid entry) and anything on the flush edge are dropped.
        cdb_go         = bus.cdb_valid && flags[bus.cdb_tag].valid && !flush_pending;
    end

    // Entry status bits: CDB marks ready, dispatch allocates, retire frees.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) flags[i] <= '0;
        end else if (flush_pending) begin
            for (int i = 0; i < DEPTH; i++) flags[i] <= '0;
        end else begin
            if (cdb_go) begin
                flags[bus.cdb_tag].ready   <= 1'b1;
                flags[bus.cdb_tag].mispred <= bus.cdb_mispredict;
            end
            if (disp_go) begin
                flags[tail] <= '{valid: 1'b1, ready: 1'b0, mispred: 1'b0,
                                 itype: bus.disp_type};
            end
            if (retire_go) flags[head].valid <= 1'b0;
        end
    end

    // Entry payload; qualified by the status bits so it needs no reset.
    always_ff @(posedge clock) begin
        if (disp_go) begin
            ent_rd[tail]   <= bus.disp_rd_reg;
            ent_pc[tail]   <= bus.disp_pc;
            ent_data[tail] <= '0;
        end
        if (cdb_go) ent_data[bus.cdb_tag] <= bus.cdb_data;
    end

    // Head/tail pointers and occupancy counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush_pending) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (disp_go)   tail <= tail + 1'b1;
            if (retire_go) head <= head + 1'b1;
            case ({disp_go, retire_go})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Registered retire port; payload holds between retires.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.retire_valid      <= 1'b0;
            bus.retire_tag        <= '0;
            bus.retire_rd_reg     <= '0;
            bus.retire_type       <= '0;
            bus.retire_data       <= '0;
            bus.retire_pc         <= '0;
            bus.retire_mispredict <= 1'b0;
            bus.flush             <= 1'b0;
        end else begin
            bus.retire_valid <= retire_go;
            bus.flush        <= flush_pending;
            if (retire_go) begin
                bus.retire_tag        <= head;
                bus.retire_rd_reg     <= ent_rd[head];
                bus.retire_type       <= head_flags.itype;
                bus.retire_data       <= ent_data[head];
                bus.retire_pc         <= ent_pc[head];
                bus.retire_mispredict <= head_flags.mispred;
            end
        end
    end

    rob_rename_map #(
        .NUM_REGS (NUM_REGS),
        .TAG_W    (TAG_W)
    ) u_map (
        .clock     (clock),
        .reset     (reset),
        .set_en    (disp_go && bus.disp_type == INST_REG),
        .set_reg   (bus.disp_rd_reg),
        .set_tag   (tail),
        .clr_en    (retire_go && head_flags.itype == INST_REG),
        .clr_reg   (ent_rd[head]),
        .clr_tag   (head),
        .clr_all   (flush_pending),
        .rd_a_reg  (bus.rs_reg),
        .rd_a_busy (rs_map_busy),
        .rd_a_tag  (rs_map_tag),
        .rd_b_reg  (bus.rt_reg),
        .rd_b_busy (rt_map_busy),
        .rd_b_tag  (rt_map_tag)
    );

    // Operand queries: entry contents with same-cycle CDB bypass; all zero
    // when no producer is pending so the caller uses the register file.
    always_comb begin
        bus.rs_busy       = rs_map_busy;
        bus.rs_tag        = '0;
        bus.rs_data_valid = 1'b0;
        bus.rs_data       = '0;
        if (rs_map_busy) begin
            bus.rs_tag = rs_map_tag;
            if (bus.cdb_valid && bus.cdb_tag == rs_map_tag) begin
                bus.rs_data_valid = 1'b1;
                bus.rs_data       = bus.cdb_data;
            end else begin
                bus.rs_data_valid = flags[rs_map_tag].ready;
                bus.rs_data       = ent_data[rs_map_tag];
            end
        end
        bus.rt_busy       = rt_map_busy;
        bus.rt_tag        = '0;
        bus.rt_data_valid = 1'b0;
        bus.rt_data       = '0;
        if (rt_map_busy) begin
            bus.rt_tag = rt_map_tag;
            if (bus.cdb_valid && bus.cdb_tag == rt_map_tag) begin
                bus.rt_data_valid = 1'b1;
                bus.rt_data       = bus.cdb_data;
            end else begin
                bus.rt_data_valid = flags[rt_map_tag].ready;
                bus.rt_data       = ent_data[rt_map_tag];
            end
        end
    end

endmodule : rob_circ
`default_nettype wire

// File: tb/tb_rob_circ.sv
`default_nettype none
// ============================================================================
// Module   : tb_rob_circ
// Brief    : Directed self-checking bench for rob_circ (DEPTH 32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rob_circ;
    import rob_pkg::*;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    rob_circ_if #(.DEPTH(32), .DATA_W(32), .PC_W(32), .NUM_REGS(32)) bus ();

    rob_circ #(.DEPTH(32), .DATA_W(32), .PC_W(32), .NUM_REGS(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic idle();
        bus.disp_valid     = 1'b0;
        bus.disp_rd_reg    = '0;
        bus.disp_pc        = '0;
        bus.disp_type      = '0;
        bus.cdb_valid      = 1'b0;
        bus.cdb_tag        = '0;
        bus.cdb_data       = '0;
        bus.cdb_mispredict = 1'b0;
    endtask

    task automatic disp(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] pc);
        bus.disp_valid  = 1'b1;
        bus.disp_type   = t;
        bus.disp_rd_reg = rd;
        bus.disp_pc     = pc;
    endtask

    task automatic cdb(input logic [4:0] t, input logic [31:0] d, input logic mp);
        bus.cdb_valid      = 1'b1;
        bus.cdb_tag        = t;
        bus.cdb_data       = d;
        bus.cdb_mispredict = mp;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        bus.rs_reg = '0;
        bus.rt_reg = '0;
        idle();
        step();
        step();
        check("rst_retire_valid", bus.retire_valid, 0);
        check("rst_flush",        bus.flush, 0);
        check("rst_empty",        bus.empty, 1);
        check("rst_full",         bus.full, 0);
        check("rst_occupancy",    bus.occupancy, 0);
        check("rst_disp_ready",   bus.disp_ready, 1);
        check("rst_disp_tag",     bus.disp_tag, 0);
        reset = 1'b0;
        step();

        // ---- basic dispatch, query, out-of-order CDB, in-order retire ----
        disp(INST_REG, 3, 32'h100);   #1 check("p1_tag0", bus.disp_tag, 0); step();
        disp(INST_REG, 5, 32'h104);   #1 check("p1_tag1", bus.disp_tag, 1); step();
        disp(INST_STORE, 0, 32'h108); #1 check("p1_tag2", bus.disp_tag, 2); step();
        bus.disp_valid = 1'b0;
        bus.rs_reg = 3;
        bus.rt_reg = 7;
        #1;
        check("p1_occupancy",  bus.occupancy, 3);
        check("p1_r3_busy",    bus.rs_busy, 1);
        check("p1_r3_tag",     bus.rs_tag, 0);
        check("p1_r3_dvalid",  bus.rs_data_valid, 0);
        check("p1_r7_busy",    bus.rt_busy, 0);
        cdb(1, 32'hAA, 0); step();
        cdb(0, 32'h55, 0); step();
        bus.cdb_valid = 1'b0;
        bus.rt_reg = 5;
        #1 check("p1_no_early_retire", bus.retire_valid, 0);
        step();
        check("p1_ret0_valid", bus.retire_valid, 1);
        check("p1_ret0_tag",   bus.retire_tag, 0);
        check("p1_ret0_rd",    bus.retire_rd_reg, 3);
        check("p1_ret0_data",  bus.retire_data, 32'h55);
        check("p1_ret0_type",  bus.retire_type, 0);
        check("p1_ret0_pc",    bus.retire_pc, 32'h100);
        check("p1_r3_cleared", bus.rs_busy, 0);
        check("p1_r5_still",   bus.rt_busy, 1);
        step();
        check("p1_ret1_valid", bus.retire_valid, 1);
        check("p1_ret1_tag",   bus.retire_tag, 1);
        check("p1_ret1_rd",    bus.retire_rd_reg, 5);
        check("p1_ret1_data",  bus.retire_data, 32'hAA);
        check("p1_r5_cleared", bus.rt_busy, 0);
        step();
        check("p1_store_wait",  bus.retire_valid, 0);
        check("p1_tag_hold",    bus.retire_tag, 1);
        check("p1_occupancy1",  bus.occupancy, 1);
        cdb(2, 32'h33, 0); step();
        bus.cdb_valid = 1'b0;
        check("p1_store_lat",   bus.retire_valid, 0);
        step();
        check("p1_store_valid", bus.retire_valid, 1);
        check("p1_store_tag",   bus.retire_tag, 2);
        check("p1_store_type",  bus.retire_type, 2'b10);
        check("p1_store_data",  bus.retire_data, 32'h33);
        check("p1_empty",       bus.empty, 1);

        // ---- mispredicted branch at head flushes everything ----
        disp(INST_BRANCH, 0, 32'h400); #1 check("fl_br_tag", bus.disp_tag, 3); step();
        disp(INST_REG, 8, 32'h404);  step();
        disp(INST_REG, 9, 32'h408);  step();
        disp(INST_NODEST, 0, 32'h40C); step();
        bus.disp_valid = 1'b0;
        #1 check("fl_occupancy4", bus.occupancy, 4);
        cdb(3, 32'h0, 1); step();
        cdb(5, 32'hEE, 0);
        disp(INST_REG, 10, 32'h410);
        #1 check("fl_disp_blocked", bus.disp_ready, 0);
        step();
        idle();
        bus.rs_reg = 8;
        bus.rt_reg = 9;
        #1;
        check("fl_ret_valid",  bus.retire_valid, 1);
        check("fl_ret_tag",    bus.retire_tag, 3);
        check("fl_ret_pc",     bus.retire_pc, 32'h400);
        check("fl_ret_type",   bus.retire_type, 2'b01);
        check("fl_ret_mispr",  bus.retire_mispredict, 1);
        check("fl_flush",      bus.flush, 1);
        check("fl_occupancy",  bus.occupancy, 0);
        check("fl_empty",      bus.empty, 1);
        check("fl_r8_busy",    bus.rs_busy, 0);
        check("fl_r9_busy",    bus.rt_busy, 0);
        check("fl_next_tag",   bus.disp_tag, 0);
        bus.rs_reg = 10;
        #1 check("fl_r10_busy", bus.rs_busy, 0);
        step();
        check("fl_flush_pulse", bus.flush, 0);
        check("fl_ret_pulse",   bus.retire_valid, 0);
        cdb(2, 32'h99, 0); step();
        bus.cdb_valid = 1'b0;
        check("fl_stale_occ", bus.occupancy, 0);
        step();
        check("fl_stale_ret", bus.retire_valid, 0);

        // ---- rename map keeps youngest producer; CDB bypass ----
        disp(INST_REG, 4, 32'h500); #1 check("r4_tag0", bus.disp_tag, 0); step();
        disp(INST_REG, 4, 32'h504); #1 check("r4_tag1", bus.disp_tag, 1); step();
        bus.disp_valid = 1'b0;
        cdb(0, 32'h11, 0); step();
        bus.cdb_valid = 1'b0;
        step();
        check("r4_ret_valid", bus.retire_valid, 1);
        check("r4_ret_tag",   bus.retire_tag, 0);
        check("r4_ret_data",  bus.retire_data, 32'h11);
        bus.rs_reg = 4;
        #1;
        check("r4_busy",      bus.rs_busy, 1);
        check("r4_tag",       bus.rs_tag, 1);
        check("r4_dvalid0",   bus.rs_data_valid, 0);
        cdb(1, 32'h7, 0);
        #1;
        check("r4_bypass_dv", bus.rs_data_valid, 1);
        check("r4_bypass_d",  bus.rs_data, 32'h7);
        step();
        bus.cdb_valid = 1'b0;
        #1;
        check("r4_no_retire", bus.retire_valid, 0);
        check("r4_entry_dv",  bus.rs_data_valid, 1);
        check("r4_entry_d",   bus.rs_data, 32'h7);
        step();
        check("r4_ret1_valid", bus.retire_valid, 1);
        check("r4_ret1_tag",   bus.retire_tag, 1);
        check("r4_ret1_data",  bus.retire_data, 32'h7);
        check("r4_cleared",    bus.rs_busy, 0);

        // ---- fill to full (head = tail = 2), then wrap ----
        for (int i = 0; i < 32; i++) begin
            disp(INST_NODEST, 0, 32'(i));
            #1 check("fill_tag", bus.disp_tag, 64'((2 + i) % 32));
            step();
        end
        #1;
        check("fill_full",  bus.full, 1);
        check("fill_ready", bus.disp_ready, 0);
        check("fill_occ",   bus.occupancy, 32);
        step();
        check("fill_extra_occ", bus.occupancy, 32);
        check("fill_extra_ret", bus.retire_valid, 0);
        for (int k = 0; k < 40; k++) begin
            cdb(5'((2 + k) % 32), 32'h1000 + 32'(k), 0);
            disp(INST_NODEST, 0, 32'h2000 + 32'(k));
            step();
            if (k == 0) begin
                check("wrap_first", bus.retire_valid, 0);
            end else begin
                check("wrap_valid", bus.retire_valid, 1);
                check("wrap_tag",   bus.retire_tag, 64'((1 + k) % 32));
                check("wrap_data",  bus.retire_data, 64'(32'h1000 + 32'(k - 1)));
                check("wrap_occ",   bus.occupancy, 31);
            end
        end
        idle();
        #1;
        check("pre_rst_valid", bus.retire_valid, 1);
        check("pre_rst_occ",   bus.occupancy, 31);

        // ---- asynchronous reset mid-stream ----
        reset = 1'b1;
        #1;
        check("arst_valid", bus.retire_valid, 0);
        check("arst_tag",   bus.retire_tag, 0);
        check("arst_data",  bus.retire_data, 0);
        check("arst_occ",   bus.occupancy, 0);
        check("arst_empty", bus.empty, 1);
        check("arst_full",  bus.full, 0);
        step();
        reset = 1'b0;
        step();
        step();
        check("post_rst_valid", bus.retire_valid, 0);
        check("post_rst_occ",   bus.occupancy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_rob_circ
`default_nettype wire
